el2_dec_gpr_bank: RTL and testbench

- Parametrised next-generation integer register file for the decode stage: configurable data width, register count, read-port count and write-port count.
- Adds features the fixed 3-write/2-read GPR block lacks: deterministic write-port priority, optional write-to-read bypass, and a per-register busy scoreboard for long-latency ops (loads, divides).
- Sticky same-address write-collision flag.
- Sits between decode (read/issue) and the writeback ports of the EX, LSU and DIV pipes.

---
 rtl/el2_dec_gpr_bank.sv | 123 ++++++++++++
 tb/tb_el2_dec_gpr_bank.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/el2_dec_gpr_bank.sv
// Parametrised decode-stage integer register file with prioritised write ports,
// optional write-to-read bypass, a per-register busy scoreboard and a sticky collision flag.
module el2_dec_gpr_bank #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned NREAD     = 2,
  parameter int unsigned NWRITE    = 3,
  parameter bit          BYPASS    = 1'b1,
  parameter bit          ZERO_REG0 = 1'b1,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   scan_mode,
  input  logic [NREAD*AW-1:0]    raddr,
  output logic [NREAD*XLEN-1:0]  rd,
  output logic [NREAD-1:0]       rd_busy,
  input  logic [NWRITE-1:0]      wen,
  input  logic [NWRITE*AW-1:0]   waddr,
  input  logic [NWRITE*XLEN-1:0] wd,
  input  logic                   busy_set,
  input  logic [AW-1:0]          busy_addr,
  output logic                   wr_collision,
  input  logic                   collision_clr
);

  logic            unused_scan_mode;
  logic [XLEN-1:0] regs  [DEPTH];
  logic [XLEN-1:0] wdata [DEPTH];
  logic [DEPTH-1:0] we;
  logic [DEPTH-1:0] busy_q, busy_d;
  logic            coll_q, coll_d, coll_set;

  assign unused_scan_mode = scan_mode;

  // Ascending scan lets the highest-numbered port overwrite lower ones.
  always_comb begin
    for (int unsigned r = 0; r < DEPTH; r++) begin
      we[r]    = 1'b0;
      wdata[r] = '0;
      for (int unsigned k = 0; k < NWRITE; k++) begin
        if (wen[k] && (waddr[k*AW +: AW] == AW'(r))) begin
          we[r]    = 1'b1;
          wdata[r] = wd[k*XLEN +: XLEN];
        end
      end
      if (ZERO_REG0 && (r == 0)) we[r] = 1'b0;
    end
  end

  for (genvar r = 0; r < DEPTH; r++) begin : g_reg
    if (ZERO_REG0 && (r == 0)) begin : g_zero
      assign regs[r] = '0;
    end else begin : g_flop
      logic [XLEN-1:0] reg_q;
      always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
          reg_q <= '0;
        end else if (we[r]) begin
          reg_q <= wdata[r];
        end
      end
      assign regs[r] = reg_q;
    end
  end

  // A new outstanding op issued alongside a write to the same register keeps it busy.
  always_comb begin
    for (int unsigned r = 0; r < DEPTH; r++) begin
      busy_d[r] = busy_q[r];
      if (we[r]) busy_d[r] = 1'b0;
      if (busy_set && (busy_addr == AW'(r))) busy_d[r] = 1'b1;
      if (ZERO_REG0 && (r == 0)) busy_d[r] = 1'b0;
    end
  end

  always_comb begin
    coll_set = 1'b0;
    for (int unsigned i = 0; i < NWRITE; i++) begin
      for (int unsigned j = i + 1; j < NWRITE; j++) begin
        if (wen[i] && wen[j] && (waddr[i*AW +: AW] == waddr[j*AW +: AW])) coll_set = 1'b1;
      end
    end
    coll_d = coll_set | (coll_q & ~collision_clr);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      busy_q <= '0;
      coll_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      coll_q <= coll_d;
    end
  end

  assign wr_collision = coll_q;

  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] data;
    logic            bsy;
    rd      = '0;
    rd_busy = '0;
    for (int unsigned p = 0; p < NREAD; p++) begin
      ra   = raddr[p*AW +: AW];
      data = regs[ra];
      bsy  = busy_q[ra];
      if (BYPASS && we[ra]) begin
        data = wdata[ra];
        if (!(busy_set && (busy_addr == ra))) bsy = 1'b0;
      end
      // Outputs are held at zero while reset is asserted, bypass included.
      if (!rst_l) begin
        data = '0;
        bsy  = 1'b0;
      end
      rd[p*XLEN +: XLEN] = data;
      rd_busy[p]         = bsy;
    end
  end

endmodule

// File: tb/tb_el2_dec_gpr_bank.sv
// Scoreboard bench: instance A (defaults), B (no bypass, writable x0) share stimulus;
// instance C (64-bit, 16 regs, 4 read, 1 write) runs random traffic against a model.
module tb_el2_dec_gpr_bank;

  localparam int SRdA = 0, SBusyA = 1, SCollA = 2, SRdB = 3, SBusyB = 4, SCollB = 5;
  localparam int SRdC = 6, SBusyC = 7, SCollC = 8;

  logic        clk, rst_l, scan_mode;
  logic [9:0]  raddr;
  logic [2:0]  wen;
  logic [14:0] waddr;
  logic [95:0] wd;
  logic        busy_set, collision_clr;
  logic [4:0]  busy_addr;
  logic [63:0] rd_a, rd_b;
  logic [1:0]  rdb_a, rdb_b;
  logic        coll_a, coll_b;

  logic [15:0]  raddr_c;
  logic [255:0] rd_c;
  logic [3:0]   rdb_c;
  logic [0:0]   wen_c;
  logic [3:0]   waddr_c, busy_addr_c;
  logic [63:0]  wd_c;
  logic         busy_set_c, collision_clr_c, coll_c;

  el2_dec_gpr_bank u_a (
    .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode), .raddr(raddr), .rd(rd_a),
    .rd_busy(rdb_a), .wen(wen), .waddr(waddr), .wd(wd), .busy_set(busy_set),
    .busy_addr(busy_addr), .wr_collision(coll_a), .collision_clr(collision_clr)
  );

  el2_dec_gpr_bank #(.BYPASS(1'b0), .ZERO_REG0(1'b0)) u_b (
    .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode), .raddr(raddr), .rd(rd_b),
    .rd_busy(rdb_b), .wen(wen), .waddr(waddr), .wd(wd), .busy_set(busy_set),
    .busy_addr(busy_addr), .wr_collision(coll_b), .collision_clr(collision_clr)
  );

  el2_dec_gpr_bank #(.XLEN(64), .DEPTH(16), .NREAD(4), .NWRITE(1)) u_c (
    .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode), .raddr(raddr_c), .rd(rd_c),
    .rd_busy(rdb_c), .wen(wen_c), .waddr(waddr_c), .wd(wd_c), .busy_set(busy_set_c),
    .busy_addr(busy_addr_c), .wr_collision(coll_c), .collision_clr(collision_clr_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sig;
    int          port;
    logic [63:0] val;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [63:0] m_regs [16];
  logic        m_busy [16];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] observe(input int sig, input int port);
    case (sig)
      SRdA:    return {32'h0, rd_a[port*32 +: 32]};
      SBusyA:  return {63'h0, rdb_a[port]};
      SCollA:  return {63'h0, coll_a};
      SRdB:    return {32'h0, rd_b[port*32 +: 32]};
      SBusyB:  return {63'h0, rdb_b[port]};
      SCollB:  return {63'h0, coll_b};
      SRdC:    return rd_c[port*64 +: 64];
      SBusyC:  return {63'h0, rdb_c[port]};
      default: return {63'h0, coll_c};
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input int port, input logic [63:0] v);
    exp_t e;
    e.tag = tag; e.sig = sig; e.port = port; e.val = v;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      check_eq(e.tag, observe(e.sig, e.port), e.val);
    end
  endtask

  task automatic idle();
    wen = '0; busy_set = 1'b0; collision_clr = 1'b0;
  endtask

  task automatic set_w(input int k, input logic [4:0] a, input logic [31:0] d);
    wen[k] = 1'b1;
    waddr[k*5 +: 5] = a;
    wd[k*32 +: 32] = d;
  endtask

  task automatic set_r(input int p, input logic [4:0] a);
    raddr[p*5 +: 5] = a;
  endtask

  // Expected C outputs from the model plus this cycle's inputs.
  task automatic push_c_expect();
    for (int p = 0; p < 4; p++) begin
      logic [3:0]  a;
      logic [63:0] d;
      logic        b;
      a = raddr_c[p*4 +: 4];
      d = m_regs[a];
      b = m_busy[a];
      if (wen_c[0] && waddr_c == a && a != 0) begin
        d = wd_c;
        if (!(busy_set_c && busy_addr_c == a)) b = 1'b0;
      end
      if (a == 0 || !rst_l) begin
        d = '0;
        b = 1'b0;
      end
      push("c_rd", SRdC, p, d);
      push("c_busy", SBusyC, p, {63'h0, b});
    end
    push("c_coll", SCollC, 0, 64'h0);
  endtask

  task automatic update_model_c();
    if (wen_c[0] && waddr_c != 0) begin
      m_regs[waddr_c] = wd_c;
      m_busy[waddr_c] = 1'b0;
    end
    if (busy_set_c && busy_addr_c != 0) m_busy[busy_addr_c] = 1'b1;
  endtask

  task automatic random_c(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      wen_c           = 1'($urandom_range(0, 1));
      waddr_c         = 4'($urandom_range(0, 15));
      wd_c            = {$urandom, $urandom};
      busy_set_c      = ($urandom_range(0, 3) == 0);
      busy_addr_c     = 4'($urandom_range(0, 15));
      collision_clr_c = 1'($urandom_range(0, 1));
      raddr_c         = 16'($urandom);
      push_c_expect();
      drain();
      update_model_c();
    end
  endtask

  initial begin
    rst_l = 1'b0; scan_mode = 1'b0;
    raddr = '0; waddr = '0; wd = '0; busy_addr = '0;
    idle();
    raddr_c = '0; wen_c = '0; waddr_c = '0; wd_c = '0;
    busy_set_c = 1'b0; busy_addr_c = '0; collision_clr_c = 1'b0;
    for (int r = 0; r < 16; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end

    // Reset: a write in flight must not surface on rd.
    @(negedge clk);
    set_w(0, 5'd5, 32'hAAAA_AAAA); set_r(0, 5'd5);
    push("rst_bypass_rd", SRdA, 0, 64'h0);
    drain();
    idle();
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      set_r(0, 5'(a)); set_r(1, 5'(a ^ 1));
      push("rst_rd0", SRdA, 0, 64'h0);
      push("rst_rd1", SRdA, 1, 64'h0);
      push("rst_busy0", SBusyA, 0, 64'h0);
      push("rst_busy1", SBusyA, 1, 64'h0);
      push("rst_coll", SCollA, 0, 64'h0);
      push("rst_rd_b", SRdB, 0, 64'h0);
      drain();
    end
    @(negedge clk);
    rst_l = 1'b1;
    set_r(0, 5'd5);
    push("post_rst_r5", SRdA, 0, 64'h0);
    drain();

    // Priority and collision.
    @(negedge clk);
    set_w(0, 5'd5, 32'h1111_1111); set_w(2, 5'd5, 32'h3333_3333); set_r(0, 5'd5);
    push("prio_byp_a", SRdA, 0, 64'h3333_3333);
    push("prio_nobyp_b", SRdB, 0, 64'h0);
    drain();
    @(negedge clk);
    idle(); collision_clr = 1'b1;
    push("prio_a", SRdA, 0, 64'h3333_3333);
    push("prio_b", SRdB, 0, 64'h3333_3333);
    push("coll_set_a", SCollA, 0, 64'h1);
    push("coll_set_b", SCollB, 0, 64'h1);
    drain();
    @(negedge clk);
    idle();
    push("coll_clr_a", SCollA, 0, 64'h0);
    drain();
    @(negedge clk);
    set_w(0, 5'd9, 32'h1); set_w(1, 5'd9, 32'h2); collision_clr = 1'b1; set_r(1, 5'd9);
    drain();
    @(negedge clk);
    idle();
    push("set_wins_a", SCollA, 0, 64'h1);
    push("prio_p1_r9", SRdA, 1, 64'h2);
    drain();

    // Bypass.
    @(negedge clk);
    set_w(1, 5'd7, 32'hDEAD_BEEF); set_r(0, 5'd7);
    push("byp_a", SRdA, 0, 64'hDEAD_BEEF);
    push("nobyp_old_b", SRdB, 0, 64'h0);
    drain();
    @(negedge clk);
    idle();
    push("byp_next_a", SRdA, 0, 64'hDEAD_BEEF);
    push("nobyp_next_b", SRdB, 0, 64'hDEAD_BEEF);
    drain();

    // Scoreboard.
    @(negedge clk);
    busy_set = 1'b1; busy_addr = 5'd12; set_r(0, 5'd12);
    push("busy_same_cyc", SBusyA, 0, 64'h0);
    drain();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      idle();
      push("busy_hold_a", SBusyA, 0, 64'h1);
      push("busy_hold_b", SBusyB, 0, 64'h1);
      drain();
    end
    @(negedge clk);
    set_w(0, 5'd12, 32'h42);
    push("busy_byp_clr_a", SBusyA, 0, 64'h0);
    push("busy_stored_b", SBusyB, 0, 64'h1);
    drain();
    @(negedge clk);
    idle();
    push("busy_clr_a", SBusyA, 0, 64'h0);
    push("busy_clr_b", SBusyB, 0, 64'h0);
    push("r12_a", SRdA, 0, 64'h42);
    drain();
    @(negedge clk);
    set_w(2, 5'd12, 32'h55); busy_set = 1'b1; busy_addr = 5'd12;
    push("busy_setwr_byp", SBusyA, 0, 64'h0);
    drain();
    @(negedge clk);
    idle();
    push("busy_setwr_a", SBusyA, 0, 64'h1);
    push("busy_setwr_b", SBusyB, 0, 64'h1);
    push("setwr_data_a", SRdA, 0, 64'h55);
    drain();

    // Register 0.
    @(negedge clk);
    set_w(0, 5'd0, 32'hFFFF_FFFF); busy_set = 1'b1; busy_addr = 5'd0; set_r(1, 5'd0);
    push("x0_byp_rd", SRdA, 1, 64'h0);
    push("x0_byp_busy", SBusyA, 1, 64'h0);
    drain();
    @(negedge clk);
    idle();
    push("x0_rd_a", SRdA, 1, 64'h0);
    push("x0_busy_a", SBusyA, 1, 64'h0);
    push("x0_rd_b", SRdB, 1, 64'hFFFF_FFFF);
    push("x0_busy_b", SBusyB, 1, 64'h1);
    drain();

    // Wide configuration: random traffic, async reset mid-run, then more traffic.
    random_c(5000);
    @(negedge clk);
    wen_c = 1'b1; waddr_c = 4'd3; wd_c = 64'h0123_4567_89AB_CDEF; raddr_c = 16'h3333;
    rst_l = 1'b0;
    push_c_expect();
    drain();
    for (int r = 0; r < 16; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    @(negedge clk);
    rst_l = 1'b1; wen_c = 1'b0; busy_set_c = 1'b0;
    for (int a = 0; a < 16; a += 4) begin
      raddr_c = {4'(a + 3), 4'(a + 2), 4'(a + 1), 4'(a)};
      push_c_expect();
      drain();
      @(negedge clk);
    end
    random_c(5000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
